// File: rtl/load_use_stall_ctrl.sv
// -----------------------------------------------------------------------------
// load_use_stall_ctrl
//
// Purpose:
//   Load-use hazard controller for a 5-stage MIPS pipeline. It sits between the
//   ID/EX and IF/ID pipeline registers. When the instruction in ID reads a
//   register that a load in EX will write, it stalls for LOAD_LAT cycles. During
//   the stall it freezes the PC and IF/ID and sends bubbles into ID/EX.
//   Single-cycle memory needs LOAD_LAT=1. Multi-cycle data memory needs
//   LOAD_LAT>1 and uses the HOLD state.
//
// Parameters:
//   REG_AW       register address width
//   LOAD_LAT     stall cycles per load-use hazard (1..15)
//   ZERO_EXEMPT  1: register 0 never creates a hazard
//   CNT_W        width of the saturating stall counter
//
// Ports:
//   clk           pipeline clock, rising edge
//   rst           asynchronous active-high reset
//   idex_memread  instruction in EX is a load
//   idex_rt       destination register of the load in EX
//   ifid_rs       rs field of the instruction in ID
//   ifid_rt       rt field of the instruction in ID
//   ifid_use_rs   ID instruction reads rs
//   ifid_use_rt   ID instruction reads rt
//   flush         IF/ID flush this cycle (wins over any stall)
//   stall         hazard stall active this cycle (combinational)
//   pc_write      PC write enable (= ~stall)
//   ifid_write    IF/ID write enable (= ~stall)
//   idex_bubble   zero the ID/EX control fields (= stall)
//   stall_cnt     stall cycles since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module load_use_stall_ctrl #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int ZERO_EXEMPT = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_rt,
  input  logic [REG_AW-1:0] ifid_rs,
  input  logic [REG_AW-1:0] ifid_rt,
  input  logic              ifid_use_rs,
  input  logic              ifid_use_rt,
  input  logic              flush,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_t;

  // The first stall cycle happens in IDLE. HOLD covers the remaining LOAD_LAT-1 cycles.
  localparam logic [3:0] HOLD_CYCLES = 4'(LOAD_LAT - 1);

  state_t           state_reg;
  logic [3:0]       remain_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic rs_match;
  logic rt_match;
  logic zero_exempt;
  logic hit;

  // Each comparison is masked by its use bit, so an X in an unused field has no effect.
  assign rs_match    = ifid_use_rs && (ifid_rs == idex_rt);
  assign rt_match    = ifid_use_rt && (ifid_rt == idex_rt);
  assign zero_exempt = (ZERO_EXEMPT != 0) && (idex_rt == '0);
  assign hit         = idex_memread && (rs_match || rt_match) && !zero_exempt;

  // Zero-latency stall. HOLD ignores the ID/EX inputs because they are already bubbles.
  // While rst is high the outputs are forced to the idle values.
  always_comb begin
    stall = 1'b0;
    if (!rst && !flush) begin
      if (state_reg == HOLD) stall = 1'b1;
      else                   stall = hit;
    end
  end

  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;
  assign stall_cnt   = cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      remain_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      if (stall && (cnt_reg != '1)) cnt_reg <= cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (stall && (LOAD_LAT > 1)) begin
            state_reg  <= HOLD;
            remain_reg <= HOLD_CYCLES;
          end
        end
        HOLD: begin
          if (flush) begin
            state_reg  <= IDLE;
            remain_reg <= '0;
          end else begin
            remain_reg <= remain_reg - 1'b1;
            if (remain_reg == 4'd1) state_reg <= IDLE;
          end
        end
        default: begin
          state_reg  <= IDLE;
          remain_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench for load_use_stall_ctrl. Five instances share one stimulus stream.
//   u1 : LOAD_LAT=1
//   u3 : LOAD_LAT=3
//   u4 : LOAD_LAT=4
//   uz : LOAD_LAT=1, ZERO_EXEMPT=0
//   uc : LOAD_LAT=1, CNT_W=2
// Inputs change 1 ns after the rising edge. Outputs are sampled on the falling edge.
module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       memread = 1'b0;
  logic [4:0] ex_rt = '0;
  logic [4:0] id_rs = '0;
  logic [4:0] id_rt = '0;
  logic       use_rs = 1'b0;
  logic       use_rt = 1'b0;
  logic       flush = 1'b0;

  logic        st1, pw1, iw1, bb1;
  logic [15:0] cnt1;
  logic        st3, pw3, iw3, bb3;
  logic [15:0] cnt3;
  logic        st4, pw4, iw4, bb4;
  logic [15:0] cnt4;
  logic        stz, pwz, iwz, bbz;
  logic [15:0] cntz;
  logic        stc, pwc, iwc, bbc;
  logic [1:0]  cntc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .idex_memread(memread), .idex_rt(ex_rt), .ifid_rs(id_rs),
    .ifid_rt(id_rt), .ifid_use_rs(use_rs), .ifid_use_rt(use_rt), .flush(flush),
    .stall(st1), .pc_write(pw1), .ifid_write(iw1), .idex_bubble(bb1), .stall_cnt(cnt1));

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(3), .ZERO_EXEMPT(1), .CNT_W(16)) u3 (
    .clk(clk), .rst(rst), .idex_memread(memread), .idex_rt(ex_rt), .ifid_rs(id_rs),
    .ifid_rt(id_rt), .ifid_use_rs(use_rs), .ifid_use_rt(use_rt), .flush(flush),
    .stall(st3), .pc_write(pw3), .ifid_write(iw3), .idex_bubble(bb3), .stall_cnt(cnt3));

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(4), .ZERO_EXEMPT(1), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .idex_memread(memread), .idex_rt(ex_rt), .ifid_rs(id_rs),
    .ifid_rt(id_rt), .ifid_use_rs(use_rs), .ifid_use_rt(use_rt), .flush(flush),
    .stall(st4), .pc_write(pw4), .ifid_write(iw4), .idex_bubble(bb4), .stall_cnt(cnt4));

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(0), .CNT_W(16)) uz (
    .clk(clk), .rst(rst), .idex_memread(memread), .idex_rt(ex_rt), .ifid_rs(id_rs),
    .ifid_rt(id_rt), .ifid_use_rs(use_rs), .ifid_use_rt(use_rt), .flush(flush),
    .stall(stz), .pc_write(pwz), .ifid_write(iwz), .idex_bubble(bbz), .stall_cnt(cntz));

  load_use_stall_ctrl #(.REG_AW(5), .LOAD_LAT(1), .ZERO_EXEMPT(1), .CNT_W(2)) uc (
    .clk(clk), .rst(rst), .idex_memread(memread), .idex_rt(ex_rt), .ifid_rs(id_rs),
    .ifid_rt(id_rt), .ifid_use_rs(use_rs), .ifid_use_rt(use_rt), .flush(flush),
    .stall(stc), .pc_write(pwc), .ifid_write(iwc), .idex_bubble(bbc), .stall_cnt(cntc));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urs, input logic urt, input logic fl);
    memread = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    use_rs = urs; use_rt = urt; flush = fl;
  endtask

  // Standard hazard: a load to r8 in EX, and the ID instruction reads rs=r8.
  task automatic hit8();
    drive(1'b1, 5'd8, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic bubble();
    drive(1'b0, 5'd0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    bubble();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Hold reset with a live hazard on the inputs. The outputs must stay idle.
    hit8();
    tick();
    sample();
    $display("reset: stall=%0b pc_write=%0b cnt=%0d", st1, pw1, cnt1);
    check_eq("rst_stall", 32'(st1), 32'd0);
    check_eq("rst_pc_write", 32'(pw1), 32'd1);
    check_eq("rst_ifid_write", 32'(iw1), 32'd1);
    check_eq("rst_bubble", 32'(bb1), 32'd0);
    check_eq("rst_cnt", 32'(cnt1), 32'd0);
    tick();
    rst = 1'b0;

    // Test 1: LOAD_LAT=1 gives exactly one stall cycle.
    do_reset();
    hit8();
    sample();
    $display("t1 cycle0: stall=%0b pc_write=%0b", st1, pw1);
    check_eq("t1_stall_c0", 32'(st1), 32'd1);
    check_eq("t1_pc_write_c0", 32'(pw1), 32'd0);
    check_eq("t1_ifid_write_c0", 32'(iw1), 32'd0);
    check_eq("t1_bubble_c0", 32'(bb1), 32'd1);
    tick();
    bubble();
    sample();
    $display("t1 cycle1: stall=%0b cnt=%0d", st1, cnt1);
    check_eq("t1_stall_c1", 32'(st1), 32'd0);
    check_eq("t1_pc_write_c1", 32'(pw1), 32'd1);
    check_eq("t1_cnt", 32'(cnt1), 32'd1);
    tick();

    // Test 2: LOAD_LAT=3 stalls for 1,1,1,0. A back-to-back hazard then follows.
    do_reset();
    hit8();
    for (int c = 0; c < 4; c++) begin
      sample();
      $display("t2 cycle%0d: stall=%0b", c, st3);
      check_eq($sformatf("t2_stall_c%0d", c), 32'(st3), (c < 3) ? 32'd1 : 32'd0);
      tick();
      bubble();
    end
    check_eq("t2_cnt", 32'(cnt3), 32'd3);
    // Back-to-back: the last stall cycle is c2 and the FSM is IDLE at c3. A new hit at c3
    // must start a fresh 3-cycle stall.
    do_reset();
    hit8();
    for (int c = 0; c < 7; c++) begin
      sample();
      $display("t2b cycle%0d: stall=%0b", c, st3);
      check_eq($sformatf("t2b_stall_c%0d", c), 32'(st3), (c < 6) ? 32'd1 : 32'd0);
      tick();
      if (c == 2) hit8();
      else        bubble();
    end
    check_eq("t2b_cnt", 32'(cnt3), 32'd6);

    // Test 3: a load to r0. Exempt unless ZERO_EXEMPT=0.
    do_reset();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    sample();
    $display("t3: stall_exempt=%0b stall_noexempt=%0b", st1, stz);
    check_eq("t3_zero_exempt", 32'(st1), 32'd0);
    check_eq("t3_zero_not_exempt", 32'(stz), 32'd1);
    tick();

    // Test 4: rt matches, but the ID instruction does not read rt.
    do_reset();
    drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    sample();
    $display("t4a: stall=%0b", st1);
    check_eq("t4_use_rt_masked", 32'(st1), 32'd0);
    tick();
    // Same rt hit with use_rt=1 and flush=1. Flush wins, so no stall and no count.
    drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1);
    sample();
    $display("t4b: stall=%0b stall3=%0b", st1, st3);
    check_eq("t4_flush_stall", 32'(st1), 32'd0);
    check_eq("t4_flush_stall_lat3", 32'(st3), 32'd0);
    tick();
    bubble();
    sample();
    $display("t4b: cnt=%0d cnt3=%0d", cnt1, cnt3);
    check_eq("t4_flush_cnt", 32'(cnt1), 32'd0);
    check_eq("t4_flush_cnt_lat3", 32'(cnt3), 32'd0);
    tick();
    // A flush during HOLD (LOAD_LAT=3) aborts the stall.
    do_reset();
    hit8();
    sample();
    check_eq("t4c_stall_c0", 32'(st3), 32'd1);
    tick();
    drive(1'b0, 5'd0, 5'd8, 5'd2, 1'b1, 1'b0, 1'b1);
    sample();
    $display("t4c: stall during flush=%0b", st3);
    check_eq("t4c_stall_flush", 32'(st3), 32'd0);
    tick();
    bubble();
    sample();
    $display("t4c: stall after flush=%0b cnt=%0d", st3, cnt3);
    check_eq("t4c_stall_after", 32'(st3), 32'd0);
    check_eq("t4c_cnt", 32'(cnt3), 32'd1);
    tick();

    // Test 5: LOAD_LAT=4, with an asynchronous reset in the 2nd stall cycle.
    do_reset();
    hit8();
    sample();
    check_eq("t5_stall_c0", 32'(st4), 32'd1);
    tick();
    bubble();
    sample();
    check_eq("t5_stall_c1", 32'(st4), 32'd1);
    #1 rst = 1'b1;
    #1;
    $display("t5: during rst stall=%0b cnt=%0d", st4, cnt4);
    check_eq("t5_rst_stall", 32'(st4), 32'd0);
    check_eq("t5_rst_cnt", 32'(cnt4), 32'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      $display("t5 post cycle%0d: stall=%0b", c, st4);
      check_eq($sformatf("t5_post_stall_c%0d", c), 32'(st4), 32'd0);
      tick();
    end

    // Test 6: CNT_W=2 saturates at 3. The 16-bit counter keeps counting.
    do_reset();
    for (int h = 0; h < 4; h++) begin
      hit8();
      tick();
      bubble();
      sample();
      $display("t6 hazard%0d: cnt2=%0d cnt16=%0d", h, cntc, cnt1);
      check_eq($sformatf("t6_cnt2_h%0d", h), 32'(cntc), (h < 3) ? 32'(h + 1) : 32'd3);
      check_eq($sformatf("t6_cnt16_h%0d", h), 32'(cnt1), 32'(h + 1));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
